sign_narrow_pack: RTL

Saturating narrow-and-pack unit: the inverse direction of the datapath's 2-bit→8-bit immediate sign extension. It accepts a stream of 8-bit two's-complement values and clamps each to the 2-bit signed range −2..+1. It packs four consecutive 2-bit lanes into one 8-bit word for the instruction/immediate memory writer. Input and output use valid/ready handshakes, with a one-word output register and a sticky overflow flag.

---
 rtl/narrow_pkg.sv | 17 +
 rtl/sat_narrow.sv | 27 ++
 rtl/sign_narrow_pack.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/narrow_pkg.sv
// Shared constants and state type for the saturating narrow-and-pack unit.
package narrow_pkg;

  // Clamp limits of a 2-bit signed lane.
  localparam logic [1:0] LANE_MAX = 2'b01;  // +1
  localparam logic [1:0] LANE_MIN = 2'b10;  // -2

  // Width of the filled-lane count that accompanies each packed word.
  localparam int unsigned CNT_W = 3;

  // FILLING: no word held, OUT_VALID low. HOLDING: a packed word waits for pop.
  typedef enum logic [0:0] {
    StFilling,
    StHolding
  } pack_state_e;

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed clamp of an IN_W-bit value into a LANE_W-bit lane.
module sat_narrow
  import narrow_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned LANE_W = 2
) (
  input  logic [IN_W-1:0]   val_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              sat_o
);

  // Bits that must all equal the lane sign bit for the value to fit unchanged.
  logic [IN_W-LANE_W:0] upper;

  assign upper = val_i[IN_W-1:LANE_W-1];

  // Clamp toward the limit that matches the input sign when the value does not fit.
  always_comb begin
    sat_o  = !((&upper) || !(|upper));
    lane_o = val_i[LANE_W-1:0];
    if (sat_o) begin
      lane_o = val_i[IN_W-1] ? LANE_MIN : LANE_MAX;
    end
  end

endmodule

// File: rtl/sign_narrow_pack.sv
// Narrows a signed input stream to 2-bit lanes and packs them into words, with
// valid/ready on both sides, a one-word output register and a sticky overflow flag.
module sign_narrow_pack
  import narrow_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned LANE_W = 2,
  parameter int unsigned LANES  = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [IN_W-1:0]          IN,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic                     IN_LAST,
  output logic [LANE_W*LANES-1:0]  OUT,
  output logic [CNT_W-1:0]         OUT_CNT,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     OVF,
  input  logic                     OVF_CLR
);

  localparam int unsigned OutW = LANE_W * LANES;
  localparam int unsigned PtrW = (LANES > 1) ? $clog2(LANES) : 1;

  pack_state_e       state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [OutW-1:0]   acc_q, acc_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [LANE_W-1:0] lane;
  logic              sat;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              pop;
  logic              last_lane;
  logic              close;
  logic [OutW-1:0]   acc_new;

  sat_narrow #(
    .IN_W   (IN_W),
    .LANE_W (LANE_W)
  ) u_sat_narrow (
    .val_i  (IN),
    .lane_o (lane),
    .sat_o  (sat)
  );

  // Handshake decode; IN_READY depends only on held state and OUT_READY.
  always_comb begin
    out_valid = (state_q == StHolding);
    in_ready  = !out_valid || OUT_READY;
    accept    = IN_VALID && in_ready;
    pop       = out_valid && OUT_READY;
    last_lane = (ptr_q == PtrW'(LANES - 1));
    close     = accept && (IN_LAST || last_lane);
  end

  // Accumulator with the incoming lane written at the pointer position.
  // Lanes above the pointer are already zero because the accumulator clears on close.
  always_comb begin
    acc_new = acc_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (ptr_q == PtrW'(i)) begin
        acc_new[i*LANE_W +: LANE_W] = lane;
      end
    end
  end

  // Lane pointer, accumulator and output word next-state.
  always_comb begin
    ptr_d = ptr_q;
    acc_d = acc_q;
    out_d = out_q;
    cnt_d = cnt_q;
    if (close) begin
      out_d = acc_new;
      cnt_d = CNT_W'(ptr_q) + CNT_W'(1);
      acc_d = '0;
      ptr_d = '0;
    end else if (accept) begin
      acc_d = acc_new;
      ptr_d = ptr_q + PtrW'(1);
    end
  end

  // FILLING/HOLDING next-state; a close during a pop keeps HOLDING with no bubble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFilling: begin
        if (close) begin
          state_d = StHolding;
        end
      end
      StHolding: begin
        if (pop && !close) begin
          state_d = StFilling;
        end
      end
      default: state_d = StFilling;
    endcase
  end

  // Sticky overflow; a saturated accept wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
    if (accept && sat) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StFilling;
      ptr_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output drive.
  always_comb begin
    IN_READY  = in_ready;
    OUT       = out_q;
    OUT_CNT   = cnt_q;
    OUT_VALID = out_valid;
    OVF       = ovf_q;
  end

endmodule
